mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/rv32i_pkg.sv | 27 ++
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared rv32i types: memory arbiter FSM state, grant encoding and the
// round-robin pick used by the fetch/data memory arbiter.
package rv32i_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // On contention the port that was not served last wins; a lone requester always wins.
    function automatic grant_t rr_pick(input logic fetch_req, input logic data_req,
                                       input grant_t last);
        if (fetch_req && data_req)
            return (last == GRANT_D) ? GRANT_I : GRANT_D;
        else if (fetch_req)
            return GRANT_I;
        else
            return GRANT_D;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between instruction fetch
// and data load/store; one access every two cycles when both ports are busy.
//
// Handshake: a port holds req (and its address/data) until it sees a one-cycle
// ack, which marks the cycle the RAM is driven; reads return a one-cycle rvalid
// on the following cycle, qualifying the combinational rdata. Stores get no rvalid.
module mem_arbiter
    import rv32i_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic                  i_rvalid,
    output logic [WIDTH-1:0]      i_rdata,

    input  logic                  d_req,
    input  logic                  d_wren,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0]      d_wdata,
    output logic                  d_ack,
    output logic                  d_rvalid,
    output logic [WIDTH-1:0]      d_rdata,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wren,
    output logic [WIDTH-1:0]      ram_wdata,
    input  logic [WIDTH-1:0]      ram_rdata,

    output arb_state_t            dbg_state
);

    arb_state_t state;
    grant_t     grant;
    grant_t     last_grant;
    grant_t     next_grant;
    logic       req_any;

    assign req_any    = i_req | d_req;
    assign i_rdata    = ram_rdata;
    assign d_rdata    = ram_rdata;
    assign dbg_state  = state;

    always_comb begin
        next_grant = rr_pick(i_req, d_req, last_grant);
    end

    // All outputs are registered so the RAM drive, ack and rvalid line up with
    // the ACCESS and RESP states and collapse to zero the instant rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GRANT_I;
            last_grant <= GRANT_D;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            ram_addr   <= '0;
            ram_wren   <= 1'b0;
            ram_wdata  <= '0;
        end else begin
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            ram_addr  <= '0;
            ram_wren  <= 1'b0;
            ram_wdata <= '0;

            case (state)
                IDLE, RESP: begin
                    if (req_any) begin
                        state      <= ACCESS;
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        if (next_grant == GRANT_I) begin
                            i_ack    <= 1'b1;
                            ram_addr <= i_addr;
                        end else begin
                            d_ack     <= 1'b1;
                            ram_addr  <= d_addr;
                            ram_wren  <= d_wren;
                            ram_wdata <= d_wdata;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                ACCESS: begin
                    state <= RESP;
                    // ram_wren still holds the access type of the cycle just finished.
                    if (!ram_wren) begin
                        if (grant == GRANT_I)
                            i_rvalid <= 1'b1;
                        else
                            d_rvalid <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM, per-cycle protocol
// monitor and a read-data scoreboard.
module tb_mem_arbiter;
    import rv32i_pkg::*;

    localparam int WIDTH      = 32;
    localparam int ADDR_WIDTH = 10;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  i_req = 1'b0;
    logic [ADDR_WIDTH-1:0] i_addr = '0;
    logic                  i_ack, i_rvalid;
    logic [WIDTH-1:0]      i_rdata;
    logic                  d_req = 1'b0;
    logic                  d_wren = 1'b0;
    logic [ADDR_WIDTH-1:0] d_addr = '0;
    logic [WIDTH-1:0]      d_wdata = '0;
    logic                  d_ack, d_rvalid;
    logic [WIDTH-1:0]      d_rdata;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_wren;
    logic [WIDTH-1:0]      ram_wdata;
    logic [WIDTH-1:0]      ram_rdata = '0;
    arb_state_t            dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic             d_was_store = 1'b0;
    logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    mem_arbiter #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wren(d_wren), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // RAM model: mem[a] = 0x1000_0000 | a, one-cycle read latency
    initial begin
        for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = 32'h1000_0000 | i;
    end

    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // protocol monitor and read-data scoreboard
    always @(negedge clk) begin
        check("ack_onehot", 32'(i_ack & d_ack), 32'd0);
        check("rvalid_onehot", 32'(i_rvalid & d_rvalid), 32'd0);
        if (dbg_state != ACCESS) begin
            check("wren_outside_access", 32'(ram_wren), 32'd0);
            check("addr_outside_access", 32'(ram_addr), 32'd0);
        end
        if (d_ack) d_was_store = ram_wren;
        if (d_rvalid) check("no_rvalid_for_store", 32'(d_was_store), 32'd0);
        if (i_rvalid || d_rvalid) begin
            if (exp_q.size() == 0)
                check("rvalid_unexpected", 32'd1, 32'd0);
            else
                check("sb_rdata", i_rvalid ? i_rdata : d_rdata, exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
        check({tag, "_acks"}, {30'd0, i_ack, d_ack}, 32'd0);
        check({tag, "_rvalids"}, {30'd0, i_rvalid, d_rvalid}, 32'd0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_ram_wren"}, 32'(ram_wren), 32'd0);
        check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    endtask

    logic [1:0] exp_acks [8] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    logic [1:0] exp_rvs  [8] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

    initial begin
        // reset state
        #12;
        check_idle_outputs("reset");
        tick();
        rst = 1'b0;
        tick();

        // single fetch from 0x004
        i_req = 1'b1; i_addr = 10'h004;
        exp_q.push_back(32'h1000_0004);
        tick();
        check("fetch_ack", 32'(i_ack), 32'd1);
        check("fetch_ram_addr", 32'(ram_addr), 32'h004);
        check("fetch_ram_wren", 32'(ram_wren), 32'd0);
        i_req = 1'b0;
        tick();
        check("fetch_rvalid", 32'(i_rvalid), 32'd1);
        check("fetch_rdata", i_rdata, 32'h1000_0004);
        check("fetch_ack_drop", 32'(i_ack), 32'd0);
        tick();
        check_idle_outputs("fetch_done");

        // store 0xDEADBEEF to 0x010
        d_req = 1'b1; d_wren = 1'b1; d_addr = 10'h010; d_wdata = 32'hDEAD_BEEF;
        tick();
        check("store_ack", 32'(d_ack), 32'd1);
        check("store_ram_wren", 32'(ram_wren), 32'd1);
        check("store_ram_addr", 32'(ram_addr), 32'h010);
        check("store_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        tick();
        check("store_state_resp", 32'(dbg_state), 32'(RESP));
        check("store_no_rvalid", 32'(d_rvalid), 32'd0);
        tick();

        // load back 0x010
        d_req = 1'b1; d_wren = 1'b0;
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        check("load_ack", 32'(d_ack), 32'd1);
        check("load_ram_wren", 32'(ram_wren), 32'd0);
        d_req = 1'b0;
        tick();
        check("load_rvalid", 32'(d_rvalid), 32'd1);
        check("load_rdata", d_rdata, 32'hDEAD_BEEF);
        tick();

        // back-to-back: data load presented while fetch is in RESP
        i_req = 1'b1; i_addr = 10'h005;
        exp_q.push_back(32'h1000_0005);
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        check("b2b_i_ack", 32'(i_ack), 32'd1);
        i_req = 1'b0;
        d_req = 1'b1; d_wren = 1'b0; d_addr = 10'h010;
        tick();
        check("b2b_resp", 32'(dbg_state), 32'(RESP));
        check("b2b_i_rvalid", 32'(i_rvalid), 32'd1);
        tick();
        check("b2b_d_ack", 32'(d_ack), 32'd1);
        check("b2b_state_access", 32'(dbg_state), 32'(ACCESS));
        check("b2b_ram_addr", 32'(ram_addr), 32'h010);
        d_req = 1'b0;
        tick();
        check("b2b_d_rvalid", 32'(d_rvalid), 32'd1);
        tick();
        check_idle_outputs("b2b_done");

        // reset in the middle of a store ACCESS to 0x020
        d_req = 1'b1; d_wren = 1'b1; d_addr = 10'h020; d_wdata = 32'h1234_5678;
        tick();
        check("rst_mid_ack", 32'(d_ack), 32'd1);
        check("rst_mid_wren", 32'(ram_wren), 32'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        d_req = 1'b0; d_wren = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_idle_outputs("rst_release");

        // aborted store must not have reached the RAM
        d_req = 1'b1; d_addr = 10'h020;
        exp_q.push_back(32'h1000_0020);
        tick();
        d_req = 1'b0;
        tick();
        check("abort_rdata", d_rdata, 32'h1000_0020);
        tick();

        // contention from a fresh reset: fetch first, then alternate
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_req = 1'b1; i_addr = 10'h001;
        d_req = 1'b1; d_wren = 1'b0; d_addr = 10'h002;
        exp_q.push_back(32'h1000_0001);
        exp_q.push_back(32'h1000_0002);
        exp_q.push_back(32'h1000_0001);
        exp_q.push_back(32'h1000_0002);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("contend_acks_%0d", k), {30'd0, i_ack, d_ack}, {30'd0, exp_acks[k]});
            check($sformatf("contend_rvalids_%0d", k), {30'd0, i_rvalid, d_rvalid},
                  {30'd0, exp_rvs[k]});
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
        tick();
        check_idle_outputs("contend_done");
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
